// File: rtl/lru_update_ctrl.sv
// lru_update_ctrl: read-modify-write controller for a per-set 4-way LRU age store
module lru_update_ctrl #(
    parameter int NoOfSets   = 64,
    parameter int indexWidth = 6,
    parameter int CntWidth   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [indexWidth-1:0] req_index,
    input  logic                  req_hit,
    input  logic [1:0]            req_hit_way,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [1:0]            resp_way,
    output logic                  lru_err,
    output logic [indexWidth-1:0] lru_index,
    input  logic [1:0]            lruOut0,
    input  logic [1:0]            lruOut1,
    input  logic [1:0]            lruOut2,
    input  logic [1:0]            lruOut3,
    output logic [1:0]            lruIn0,
    output logic [1:0]            lruIn1,
    output logic [1:0]            lruIn2,
    output logic [1:0]            lruIn3,
    output logic                  LRUwEn,
    output logic [CntWidth-1:0]   hit_cnt,
    output logic [CntWidth-1:0]   miss_cnt
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3;
    if (NoOfSets != 2 ** indexWidth) begin : g_bad_index
        $error("indexWidth must equal clog2(NoOfSets)");
    end
    logic [1:0]            state;
    logic [indexWidth-1:0] idx;
    logic                  hit;
    logic [1:0]            way;
    logic [1:0]            age [4];
    logic [1:0]            lru_in [4];
    logic [1:0]            vic, tgt, ta;
    logic [3:0]            seen;
    logic                  err;
    always_comb begin
        vic  = 2'd0;
        seen = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (age[i] < age[vic]) vic = 2'(i);
            seen[age[i]] = 1'b1;
        end
        tgt = hit ? way : vic;
        ta  = age[tgt];
        err = seen != 4'hf;
        for (int i = 0; i < 4; i++)
            lru_in[i] = (state != WR) ? 2'd0 : (2'(i) == tgt) ? 2'd3 : (age[i] > ta) ? age[i] - 2'd1 : age[i];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            hit      <= 1'b0;
            way      <= 2'd0;
            age      <= '{default: 2'd0};
            resp_way <= 2'd0;
            lru_err  <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    idx   <= req_index;
                    hit   <= req_hit;
                    way   <= req_hit_way;
                    state <= RD;
                end
                RD: begin
                    age   <= '{lruOut0, lruOut1, lruOut2, lruOut3};
                    state <= WR;
                end
                WR: begin
                    resp_way <= tgt;
                    lru_err  <= err;
                    if (hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
                    if (!hit && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
                    state <= RESP;
                end
                default: if (resp_ready) state <= IDLE;
            endcase
        end
    end
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign LRUwEn     = state == WR;
    assign lru_index  = (state == IDLE) ? req_index : idx;
    assign lruIn0     = lru_in[0];
    assign lruIn1     = lru_in[1];
    assign lruIn2     = lru_in[2];
    assign lruIn3     = lru_in[3];
endmodule

// File: tb/tb_lru_update_ctrl.sv
// tb_lru_update_ctrl: vector table, corner sequences and random traffic against an LRU-order model
module tb_lru_update_ctrl;
    localparam int CW = 3;
    localparam int SAT = 7;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_hit = 1'b0, resp_ready = 1'b0;
    logic [5:0] req_index = '0;
    logic [1:0] req_hit_way = '0;
    logic req_ready, resp_valid, lru_err, LRUwEn;
    logic [1:0] resp_way, lruOut0, lruOut1, lruOut2, lruOut3, lruIn0, lruIn1, lruIn2, lruIn3;
    logic [5:0] lru_index;
    logic [CW-1:0] hit_cnt, miss_cnt;
    logic [1:0] mem [64][4];
    logic ovr = 1'b0;
    logic [1:0] ovr_a [4];
    logic [7:0] last_wr = '0;
    int wen_cnt = 0;
    int checks = 0, failures = 0;
    int hits = 0, misses = 0;
    int ord [64][4];

    lru_update_ctrl #(.NoOfSets(64), .indexWidth(6), .CntWidth(CW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_hit(req_hit), .req_hit_way(req_hit_way),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_way(resp_way),
        .lru_err(lru_err), .lru_index(lru_index),
        .lruOut0(lruOut0), .lruOut1(lruOut1), .lruOut2(lruOut2), .lruOut3(lruOut3),
        .lruIn0(lruIn0), .lruIn1(lruIn1), .lruIn2(lruIn2), .lruIn3(lruIn3),
        .LRUwEn(LRUwEn), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    assign lruOut0 = ovr ? ovr_a[0] : mem[lru_index][0];
    assign lruOut1 = ovr ? ovr_a[1] : mem[lru_index][1];
    assign lruOut2 = ovr ? ovr_a[2] : mem[lru_index][2];
    assign lruOut3 = ovr ? ovr_a[3] : mem[lru_index][3];

    // Stub LRU store: resets every set to ages 0,1,2,3
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 64; s++)
                for (int w = 0; w < 4; w++) mem[s][w] <= 2'(w);
        end else if (LRUwEn) begin
            mem[lru_index] <= '{lruIn0, lruIn1, lruIn2, lruIn3};
            last_wr <= {lruIn3, lruIn2, lruIn1, lruIn0};
            wen_cnt <= wen_cnt + 1;
        end
    end

    typedef struct {
        logic       h;
        logic [1:0] w;
        logic [5:0] ix;
        logic [1:0] ew;
        logic [7:0] ea;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, act, exp);
        end
    endtask

    function automatic logic [7:0] row(input logic [5:0] ix);
        return {mem[ix][3], mem[ix][2], mem[ix][1], mem[ix][0]};
    endfunction

    task automatic chk_cnts();
        chk("hit_cnt", 32'(hit_cnt), (hits > SAT) ? SAT : hits);
        chk("miss_cnt", 32'(miss_cnt), (misses > SAT) ? SAT : misses);
    endtask

    task automatic txn(input logic h, input logic [1:0] w, input logic [5:0] ix, input int hold,
                       output logic [1:0] rw, output logic re, output int nw);
        int w0;
        w0 = wen_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_hit = h; req_hit_way = w; req_index = ix;
        chk("req_ready_idle", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_ready_busy", 32'(req_ready), 0);
        @(posedge clk); #1;
        chk("wen_t2", 32'(LRUwEn), 1);
        @(posedge clk); #1;
        chk("resp_valid_t3", 32'(resp_valid), 1);
        chk("wen_off", 32'(LRUwEn), 0);
        rw = resp_way;
        re = lru_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 1);
            chk("hold_way", 32'(resp_way), 32'(rw));
            chk("hold_ready", 32'(req_ready), 0);
            chk("hold_wen", 32'(LRUwEn), 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_done", 32'(resp_valid), 0);
        nw = wen_cnt - w0;
    endtask

    task automatic model_reset();
        hits = 0;
        misses = 0;
        for (int s = 0; s < 64; s++)
            for (int k = 0; k < 4; k++) ord[s][k] = k;
    endtask

    initial begin
        logic [1:0] rw;
        logic re;
        int nw, w0, p, t;
        logic [7:0] ea;
        tbl[0] = '{1'b0, 2'd0, 6'd5, 2'd0, 8'h93};
        tbl[1] = '{1'b1, 2'd2, 6'd5, 2'd2, 8'h72};
        tbl[2] = '{1'b1, 2'd3, 6'd9, 2'd3, 8'hE4};
        tbl[3] = '{1'b0, 2'd0, 6'd5, 2'd1, 8'h2D};
        model_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_wen", 32'(LRUwEn), 0);
        chk("rst_resp_way", 32'(resp_way), 0);
        chk("rst_lru_err", 32'(lru_err), 0);
        chk("rst_lruin", {24'd0, lruIn3, lruIn2, lruIn1, lruIn0}, 0);
        chk("rst_lru_index", 32'(lru_index), 0);
        chk_cnts();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            txn(tbl[i].h, tbl[i].w, tbl[i].ix, 0, rw, re, nw);
            if (tbl[i].h) hits++; else misses++;
            chk($sformatf("vec%0d_way", i), 32'(rw), 32'(tbl[i].ew));
            chk($sformatf("vec%0d_err", i), 32'(re), 0);
            chk($sformatf("vec%0d_wen", i), nw, 1);
            chk($sformatf("vec%0d_ages", i), 32'(row(tbl[i].ix)), 32'(tbl[i].ea));
            chk_cnts();
        end

        // Non-permutation ages: victim is lowest minimum, written ages follow the update rule
        ovr = 1'b1;
        ovr_a = '{2'd1, 2'd1, 2'd2, 2'd3};
        txn(1'b0, 2'd0, 6'd20, 0, rw, re, nw);
        ovr = 1'b0;
        misses++;
        chk("err_way", 32'(rw), 0);
        chk("err_flag", 32'(re), 1);
        chk("err_written", 32'(last_wr), 32'(8'b10_01_01_11));
        chk_cnts();

        txn(1'b1, 2'd1, 6'd30, 5, rw, re, nw);
        hits++;
        chk("hold_resp_way", 32'(rw), 1);
        chk("hold_one_wen", nw, 1);
        chk("hold_ages", 32'(row(6'd30)), 32'(8'b10_01_11_00));
        chk_cnts();

        // Reset while the write is being driven
        w0 = wen_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_hit = 1'b0; req_index = 6'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_wr", 32'(LRUwEn), 1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_wen", 32'(LRUwEn), 0);
        chk("midrst_ready", 32'(req_ready), 1);
        chk("midrst_resp_valid", 32'(resp_valid), 0);
        chk_cnts();
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_no_write", wen_cnt - w0, 0);
        txn(1'b0, 2'd0, 6'd5, 0, rw, re, nw);
        misses++;
        ord[5] = '{1, 2, 3, 0};
        chk("postrst_way", 32'(rw), 0);
        chk_cnts();

        for (int i = 0; i < 80; i++) begin
            logic h;
            logic [1:0] w;
            logic [5:0] ix;
            h = 1'($urandom_range(0, 1));
            w = 2'($urandom_range(0, 3));
            ix = 6'($urandom_range(0, 3));
            t = h ? int'(w) : ord[ix][0];
            p = 0;
            for (int k = 0; k < 4; k++) if (ord[ix][k] == t) p = k;
            for (int k = p; k < 3; k++) ord[ix][k] = ord[ix][k + 1];
            ord[ix][3] = t;
            ea = '0;
            for (int k = 0; k < 4; k++) ea[2 * ord[ix][k] +: 2] = 2'(k);
            txn(h, w, ix, int'($urandom_range(0, 2)), rw, re, nw);
            if (h) hits++; else misses++;
            chk("rnd_way", 32'(rw), t);
            chk("rnd_err", 32'(re), 0);
            chk("rnd_wen", nw, 1);
            chk("rnd_ages", 32'(row(ix)), 32'(ea));
            chk_cnts();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
